// File: rtl/sound_player_if.sv
// Event handshake between the ball/collision logic and the sound player.
// The upstream side drives a 3-bit event code with a 1-cycle valid strobe.
// The player reports back whether a tone is playing and which code it is.
interface sound_player_if;
  logic [2:0] event_code;
  logic       event_valid;
  logic       busy;
  logic [2:0] cur_code;

  modport master (
    output event_code,
    output event_valid,
    input  busy,
    input  cur_code
  );

  modport slave (
    input  event_code,
    input  event_valid,
    output busy,
    output cur_code
  );
endinterface

// File: rtl/sound_player.sv
// Event-to-tone generator: one fixed-length square-wave tone per accepted
// event, with the pitch selected by the event code (1..4).
// Optional build macro SOUND_QUEUE_EN: when defined, an event arriving during
// a tone is held in a one-entry pending slot and plays after the current tone.
// When undefined, such an event restarts the tone immediately with the new code.
module sound_player #(
  parameter int HALF_P1    = 56818,
  parameter int HALF_P2    = 37879,
  parameter int HALF_P3    = 28409,
  parameter int HALF_P4    = 113636,
  parameter int DUR_CYCLES = 5000000,
  parameter int CNT_W      = 24
) (
  input  logic          clk,
  input  logic          reset,
  sound_player_if.slave bus,
  input  logic          mute,
  output logic          speaker
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  localparam logic [CNT_W-1:0] DUR_LOAD = CNT_W'(DUR_CYCLES - 1);
  localparam logic [CNT_W-1:0] H1_LOAD  = CNT_W'(HALF_P1 - 1);
  localparam logic [CNT_W-1:0] H2_LOAD  = CNT_W'(HALF_P2 - 1);
  localparam logic [CNT_W-1:0] H3_LOAD  = CNT_W'(HALF_P3 - 1);
  localparam logic [CNT_W-1:0] H4_LOAD  = CNT_W'(HALF_P4 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] dur_cnt, dur_n;
  logic [CNT_W-1:0] per_cnt, per_n;
  logic [CNT_W-1:0] per_load, load_n;
  logic             tone, tone_n;
  logic [2:0]       code_q, code_n;
  logic             accept;
  logic             tone_end;
  logic             do_start;
  logic [2:0]       start_code;

`ifdef SOUND_QUEUE_EN
  // Pending slot holds a code; zero means the slot is empty.
  logic [2:0]       pend_code, pend_n;
`endif

  // Half-period reload value for a given code; only 1..4 ever reach a start.
  function automatic logic [CNT_W-1:0] half_load(input logic [2:0] code);
    case (code)
      3'd2:    half_load = H2_LOAD;
      3'd3:    half_load = H3_LOAD;
      3'd4:    half_load = H4_LOAD;
      default: half_load = H1_LOAD;
    endcase
  endfunction

  assign accept = bus.event_valid &&
                  (bus.event_code >= 3'd1) && (bus.event_code <= 3'd4);

  assign bus.busy     = (state == PLAY);
  assign bus.cur_code = code_q;

  // Next-state logic: advance the period/duration counters and decide whether
  // the next edge starts a tone, keeps playing, or returns to idle.
  always_comb begin
    state_n    = state;
    dur_n      = dur_cnt;
    per_n      = per_cnt;
    load_n     = per_load;
    tone_n     = tone;
    code_n     = code_q;
    tone_end   = 1'b0;
    do_start   = 1'b0;
    start_code = 3'd0;
`ifdef SOUND_QUEUE_EN
    pend_n     = pend_code;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          do_start   = 1'b1;
          start_code = bus.event_code;
        end
      end
      default: begin
        if (per_cnt == '0) begin
          tone_n = ~tone;
          per_n  = per_load;
        end else begin
          per_n = per_cnt - CNT_ONE;
        end

        if (dur_cnt == '0) begin
          tone_end = 1'b1;
        end else begin
          dur_n = dur_cnt - CNT_ONE;
        end

`ifdef SOUND_QUEUE_EN
        // On the final cycle a fresh event is the most recent request, so it
        // takes priority over whatever was waiting in the slot.
        if (tone_end) begin
          if (accept) begin
            do_start   = 1'b1;
            start_code = bus.event_code;
            pend_n     = 3'd0;
          end else if (pend_code != 3'd0) begin
            do_start   = 1'b1;
            start_code = pend_code;
            pend_n     = 3'd0;
          end else begin
            state_n = IDLE;
            code_n  = 3'd0;
            tone_n  = 1'b0;
            per_n   = '0;
            dur_n   = '0;
          end
        end else if (accept) begin
          pend_n = bus.event_code;
        end
`else
        if (accept) begin
          do_start   = 1'b1;
          start_code = bus.event_code;
        end else if (tone_end) begin
          state_n = IDLE;
          code_n  = 3'd0;
          tone_n  = 1'b0;
          per_n   = '0;
          dur_n   = '0;
        end
`endif
      end
    endcase

    if (do_start) begin
      state_n = PLAY;
      code_n  = start_code;
      dur_n   = DUR_LOAD;
      load_n  = half_load(start_code);
      per_n   = half_load(start_code);
      tone_n  = 1'b0;
    end
  end

  // State registers; the speaker is registered from the next-state tone so it
  // has no lag relative to the tone itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      per_cnt  <= '0;
      per_load <= '0;
      tone     <= 1'b0;
      code_q   <= 3'd0;
      speaker  <= 1'b0;
    end else begin
      state    <= state_n;
      dur_cnt  <= dur_n;
      per_cnt  <= per_n;
      per_load <= load_n;
      tone     <= tone_n;
      code_q   <= code_n;
      speaker  <= tone_n & ~mute;
    end
  end

`ifdef SOUND_QUEUE_EN
  // Pending slot register, cleared by reset so a queued tone never survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_code <= 3'd0;
    end else begin
      pend_code <= pend_n;
    end
  end
`endif

endmodule

// File: tb/tb_sound_player.sv
// Self-checking bench for sound_player with shortened tone parameters.
// A cycle-level model tracks tone age and pending code; outputs are compared
// on every falling edge, plus hand-computed literal checks at key cycles.
module tb_sound_player;
  localparam int H1 = 4;
  localparam int H2 = 3;
  localparam int H3 = 2;
  localparam int H4 = 5;
  localparam int D  = 40;

`ifdef SOUND_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic mute;
  logic speaker;

  sound_player_if bus();

  sound_player #(
    .HALF_P1(H1), .HALF_P2(H2), .HALF_P3(H3), .HALF_P4(H4),
    .DUR_CYCLES(D), .CNT_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mute(mute),
    .speaker(speaker)
  );

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  bit m_busy = 1'b0;
  int m_code = 0;
  int m_age = 0;
  int m_pend = 0;
  bit m_spk = 1'b0;

  // Clock generation
  always #5 clk = ~clk;

  function automatic int half_of(input int code);
    case (code)
      2:       return H2;
      3:       return H3;
      4:       return H4;
      default: return H1;
    endcase
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_start(input int c);
    m_busy = 1'b1;
    m_code = c;
    m_age  = 0;
  endtask

  task automatic model_idle();
    m_busy = 1'b0;
    m_code = 0;
    m_age  = 0;
  endtask

  // Behavioural model: a tone is described by its code and its age in cycles
  // since busy rose; the tone level is simply (age / half-period) odd.
  always @(posedge clk) begin
    int c;
    bit acc;
    c   = int'(bus.event_code);
    acc = bus.event_valid && (c >= 1) && (c <= 4);
    if (reset) begin
      model_idle();
      m_pend = 0;
    end else if (!m_busy) begin
      if (acc) model_start(c);
    end else if (QUEUE) begin
      if (m_age == D - 1) begin
        if (acc) begin
          model_start(c);
          m_pend = 0;
        end else if (m_pend != 0) begin
          model_start(m_pend);
          m_pend = 0;
        end else begin
          model_idle();
        end
      end else begin
        if (acc) m_pend = c;
        m_age++;
      end
    end else begin
      if (acc) model_start(c);
      else if (m_age == D - 1) model_idle();
      else m_age++;
    end
    m_spk = m_busy && (((m_age / half_of(m_code)) % 2) == 1) && !mute;
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_busy", int'(bus.busy), int'(m_busy));
      check_output("model_cur_code", int'(bus.cur_code), m_code);
      check_output("model_speaker", int'(speaker), int'(m_spk));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int code, input bit valid, input bit mu, input bit rst);
    bus.event_code  = 3'(code);
    bus.event_valid = valid;
    mute            = mu;
    reset           = rst;
  endtask

  task automatic pulse(input int code);
    apply_stimulus(code, 1'b1, mute, 1'b0);
    tick();
    bus.event_valid = 1'b0;
  endtask

  initial begin
    int idle_codes[3];
    idle_codes = '{0, 5, 7};

    apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    tick();
    check_en = 1'b1;
    tick();
    check_output("reset_busy", int'(bus.busy), 0);
    check_output("reset_cur_code", int'(bus.cur_code), 0);
    check_output("reset_speaker", int'(speaker), 0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    check_output("idle_busy", int'(bus.busy), 0);

    // Code 1: busy after one edge, first rise 4 clk later, 40 clk long
    pulse(1);
    check_output("c1_busy_rise", int'(bus.busy), 1);
    check_output("c1_cur_code", int'(bus.cur_code), 1);
    check_output("c1_spk_e0", int'(speaker), 0);
    repeat (3) tick();
    check_output("c1_spk_e3", int'(speaker), 0);
    tick();
    check_output("c1_spk_e4", int'(speaker), 1);
    repeat (4) tick();
    check_output("c1_spk_e8", int'(speaker), 0);
    repeat (31) tick();
    check_output("c1_busy_e39", int'(bus.busy), 1);
    tick();
    check_output("c1_busy_e40", int'(bus.busy), 0);
    check_output("c1_code_e40", int'(bus.cur_code), 0);
    check_output("c1_spk_e40", int'(speaker), 0);
    repeat (3) tick();

    // Invalid codes in idle are ignored
    foreach (idle_codes[i]) begin
      pulse(idle_codes[i]);
      check_output("bad_code_busy", int'(bus.busy), 0);
      check_output("bad_code_cur", int'(bus.cur_code), 0);
      tick();
    end

    // Code 4 with a mute window over edges 10..20
    pulse(4);
    repeat (9) tick();
    mute = 1'b1;
    repeat (11) tick();
    check_output("mute_spk_e20", int'(speaker), 0);
    mute = 1'b0;
    repeat (5) tick();
    check_output("mute_phase_e25", int'(speaker), 1);
    repeat (14) tick();
    check_output("mute_busy_e39", int'(bus.busy), 1);
    tick();
    check_output("mute_busy_e40", int'(bus.busy), 0);
    repeat (3) tick();

    // Code 2 then code 3 on edge 15 of the tone
    pulse(2);
    repeat (14) tick();
    pulse(3);
    check_output("mid_cur_e15", int'(bus.cur_code), QUEUE ? 2 : 3);
    check_output("mid_busy_e15", int'(bus.busy), 1);
    repeat (24) tick();
    check_output("mid_cur_e39", int'(bus.cur_code), QUEUE ? 2 : 3);
    tick();
    check_output("mid_cur_e40", int'(bus.cur_code), 3);
    check_output("mid_busy_e40", int'(bus.busy), 1);
    repeat (45) tick();
    check_output("mid_busy_end", int'(bus.busy), 0);
    repeat (3) tick();

    // Code 2 then code 3 landing on the final cycle
    pulse(2);
    repeat (39) tick();
    pulse(3);
    check_output("final_busy_e40", int'(bus.busy), 1);
    check_output("final_cur_e40", int'(bus.cur_code), 3);
    repeat (41) tick();
    check_output("final_busy_end", int'(bus.busy), 0);
    repeat (3) tick();

    // Reset mid-tone, with a second event possibly pending
    pulse(1);
    repeat (4) tick();
    pulse(2);
    repeat (14) tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_cur_code", int'(bus.cur_code), 0);
    check_output("rst_speaker", int'(speaker), 0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (60) tick();
    check_output("rst_no_pending", int'(bus.busy), 0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sound_player.md
Name: sound_player

Overview:
- Event-to-tone generator downstream of the ball/collision logic.
- Consumes the 3-bit sound event code (wall, block hit levels, paddle/floor) and drives a 1-bit square wave to the board speaker pin.
- Plays one fixed-duration tone per accepted event; pitch is selected by the code.
- Runs entirely on the 50 MHz system clock. Upstream supplies a 1-cycle valid pulse alongside the code.

Parameters:
- HALF_P1, 56818: half-period in clk cycles for code 1 (wall/ceiling, 440 Hz)
- HALF_P2, 37879: half-period for code 2 (block hit, 660 Hz)
- HALF_P3, 28409: half-period for code 3 (block destroyed, 880 Hz)
- HALF_P4, 113636: half-period for code 4 (paddle/floor, 220 Hz)
- DUR_CYCLES, 5000000: tone length in clk cycles (100 ms)
- CNT_W, 24: width of the period and duration counters; must hold DUR_CYCLES-1 and every HALF_Pn-1

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- event_code  in  3  sound selector: 1..4 valid; 0 and 5..7 mean no sound
- event_valid  in  1  1-cycle strobe qualifying event_code
- mute  in  1  forces speaker low; all timing continues unaffected
- speaker  out  1  square-wave output
- busy  out  1  high while a tone is playing
- cur_code  out  3  code of the tone currently playing; 0 when idle

Behaviour:
- Reset values: speaker=0, busy=0, cur_code=0, state=IDLE, all counters=0, pending slot empty. Reset overrides every other input on the same edge, including mid-tone.
- Accepted event: event_valid=1 and event_code in 1..4. Any other code with valid=1 is ignored and changes no state.
- States: IDLE and PLAY.
- IDLE -> PLAY on an accepted event. Effects on the next edge:
  - busy=1, cur_code=code
  - dur_cnt=DUR_CYCLES-1, per_cnt=HALF_Pn-1, tone=0
  - Latency from valid to busy high: 1 clk.
- In PLAY, every clk:
  - if per_cnt==0: toggle tone and reload HALF_Pn-1; else decrement per_cnt.
  - if dur_cnt==0: tone ends; else decrement dur_cnt.
- Tone end with no follow-up event: go to IDLE on that edge; busy=0, cur_code=0, tone=0. Total busy-high time = DUR_CYCLES cycles exactly.
- Tone period = 2*HALF_Pn cycles. First rising edge of tone occurs HALF_Pn cycles after busy rises.
- speaker = tone AND NOT mute, registered. It lags tone by 0 cycles: the register is updated from the next-state tone value.
- Accepted event during PLAY: handling depends on the optional feature (below). The same rule applies when the event lands on the tone's final cycle (dur_cnt==0); the new event wins over return to IDLE.
- pitch is fixed from HALF_Pn latched at start. cur_code changes only at a tone start or on return to IDLE.
- Counters are unsigned CNT_W bits. There is no wrap-around: reloads occur before underflow.

Optional Feature:
- Macro: SOUND_QUEUE_EN.
- Defined: one-entry pending slot.
  - An accepted event during PLAY is stored in the slot; a later event overwrites it (last wins).
  - When the current tone ends, the pending tone starts on that same edge: busy stays 1, cur_code becomes the pending code, counters reload, tone=0, slot is cleared.
  - Event on the final cycle with an empty slot: it starts directly as the next tone.
  - Reset clears the slot.
- Undefined: preemption. An accepted event during PLAY restarts immediately on the next edge with the new code: counters reload, tone=0, busy stays 1. No slot logic is synthesised.

Test Plan:
- Test parameters: HALF_P1=4, HALF_P2=3, HALF_P3=2, HALF_P4=5, DUR_CYCLES=40.
- Reset, then idle 10 clk -> speaker=0, busy=0, cur_code=0 throughout.
- Code 1 valid for 1 clk -> next edge busy=1, cur_code=1. speaker toggles every 4 clk, first rise 4 clk after busy. busy falls exactly 40 clk after rising. speaker=0 afterward.
- Codes 0, 5 and 7 each pulsed in IDLE -> busy, cur_code and speaker stay 0.
- Code 4 started, then mute=1 for clk 10..20 -> speaker=0 during the mute window; toggle phase after mute matches an unmuted reference run; busy still lasts 40 clk.
- Code 2, then code 3 at clk 15 of the tone:
  - Queue off: restart on next edge, cur_code=3, busy high 40 clk from the restart.
  - Queue on: cur_code=2 until clk 40, then 3 with no busy gap, 80 busy clk total.
  - Repeat with the second event on clk 39 (final cycle): both modes start code 3 with no idle cycle.
- reset asserted at clk 20 of a tone -> next edge busy=0, speaker=0, cur_code=0. Queue on: a pending code is discarded and does not play after reset.
